// File: rtl/mod_addsub_seq.sv
// Modular add/subtract sequencer: drives a shared start/done adder to compute (A +/- B) mod M.
// Optional macro CONST_TIME_EN: every operation runs both adder ops for data-independent latency.
module mod_addsub_seq #(
    parameter int WIDTH = 1027
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OP1_GO   = 3'd1,
        OP1_WAIT = 3'd2,
        OP2_GO   = 3'd3,
        OP2_WAIT = 3'd4,
        FIN      = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] m_r;
    logic             sub_r;
    logic [WIDTH:0]   t_r;
    logic             op1_fast;

    // Pick the reduced value after the correction op (t = raw op, u = correction op).
    function automatic logic [WIDTH-1:0] reduce_op2(input logic           sub,
                                                    input logic [WIDTH:0] t,
                                                    input logic [WIDTH:0] u);
        logic [WIDTH-1:0] r;
        if (!sub)
            r = (t[WIDTH] || !u[WIDTH]) ? u[WIDTH-1:0] : t[WIDTH-1:0];
`ifdef CONST_TIME_EN
        else
            r = t[WIDTH] ? u[WIDTH-1:0] : t[WIDTH-1:0];
`else
        else
            r = u[WIDTH-1:0];
`endif
        return r;
    endfunction

`ifdef CONST_TIME_EN
    assign op1_fast = 1'b0;
`else
    // A subtraction without borrow is already reduced; skip the correction op.
    assign op1_fast = sub_r && !add_result[WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = OP1_GO;
            OP1_GO:   state_nxt = OP1_WAIT;
            OP1_WAIT: if (add_done) state_nxt = op1_fast ? FIN : OP2_GO;
            OP2_GO:   state_nxt = OP2_WAIT;
            OP2_WAIT: if (add_done) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_start = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE:               ;
            OP1_GO, OP2_GO:     begin add_start = 1'b1; busy = 1'b1; end
            OP1_WAIT, OP2_WAIT: busy = 1'b1;
            FIN:                begin done = 1'b1; busy = 1'b1; end
            default:            ;
        endcase
    end

    // Adder operands only change on accepted start or on op1 completion, so they stay
    // stable from each GO cycle until the matching add_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            add_in_a     <= '0;
            add_in_b     <= '0;
            add_subtract <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        add_in_a     <= in_a;
                        add_in_b     <= in_b;
                        add_subtract <= subtract;
                        m_r          <= in_m;
                        sub_r        <= subtract;
                    end
                end
                OP1_WAIT: begin
                    if (add_done) begin
                        t_r          <= add_result;
                        add_in_a     <= add_result[WIDTH-1:0];
                        add_in_b     <= m_r;
                        add_subtract <= !sub_r;
                        if (op1_fast)
                            result <= add_result[WIDTH-1:0];
                    end
                end
                OP2_WAIT: begin
                    if (add_done)
                        result <= reduce_op2(sub_r, t_r, add_result);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Randomized self-checking bench for mod_addsub_seq with a behavioural adder responder.
module tb_mod_addsub_seq;
    localparam int W = 1027;
    typedef logic [W:0] wv_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic [W-1:0] result, add_in_a, add_in_b;
    logic         busy, done, add_start, add_subtract;
    logic [W:0]   add_result = '0;
    logic         add_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int adder_lat = 1;

    always #5 clk = ~clk;

    mod_addsub_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .result(result), .busy(busy), .done(done),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_result(add_result), .add_done(add_done)
    );

    task automatic chk(input string tag, input wv_t got, input wv_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Raw adder behaviour: WIDTH+1-bit sum, or difference whose top bit is the borrow.
    function automatic wv_t raw_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    logic         mdl_busy = 1'b0;
    int           mdl_cnt = 0;
    logic [W:0]   mdl_res = '0;
    logic [W-1:0] cap_a = '0, cap_b = '0;
    logic         cap_sub = 1'b0;

    always @(posedge clk) begin
        add_done <= 1'b0;
        if (mdl_busy) begin
            if (mdl_cnt <= 1) begin
                add_done   <= 1'b1;
                add_result <= mdl_res;
                mdl_busy   <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end else if (add_start) begin
            cap_a   <= add_in_a;
            cap_b   <= add_in_b;
            cap_sub <= add_subtract;
            if (adder_lat <= 1) begin
                add_done   <= 1'b1;
                add_result <= raw_op(add_in_a, add_in_b, add_subtract);
            end else begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= adder_lat - 1;
                mdl_res  <= raw_op(add_in_a, add_in_b, add_subtract);
            end
        end
    end

    always @(negedge clk) begin
        if (busy && (add_done || mdl_busy))
            chk("adder_operand_hold",
                wv_t'({add_in_a == cap_a, add_in_b == cap_b, add_subtract == cap_sub}),
                wv_t'(3'b111));
    end

    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m, input logic s);
        logic [W+1:0] r;
        if (!s) begin
            r = {2'b00, a} + {2'b00, b};
            if (r >= {2'b00, m}) r = r - {2'b00, m};
        end else if (a >= b) begin
            r = {2'b00, a} - {2'b00, b};
        end else begin
            r = {2'b00, a} + {2'b00, m} - {2'b00, b};
        end
        return r[W-1:0];
    endfunction

    function automatic int exp_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
`ifdef CONST_TIME_EN
        return 2;
`else
        return (s && a >= b) ? 1 : 2;
`endif
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W+31:0] v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++)
            v = (v << 32) | {{W{1'b0}}, $urandom()};
        return v[W-1:0];
    endfunction

    // Runs one operation from the current cycle (drives start in cycle 0).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                          input logic s, input bit spam,
                          output int lat_cyc, output int pulses, output logic [W-1:0] res,
                          output logic op2_sub, output logic [W-1:0] op2_b);
        int cyc;
        start = 1'b1; in_a = a; in_b = b; in_m = m; subtract = s;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; pulses = 0; lat_cyc = -1; res = '0; op2_sub = 1'b0; op2_b = '0;
        chk("busy_after_start", wv_t'(busy), wv_t'(1'b1));
        while (cyc <= 300) begin
            if (add_start) begin
                pulses++;
                if (pulses == 2) begin
                    op2_sub = add_subtract;
                    op2_b   = add_in_b;
                end
            end
            if (done) begin
                lat_cyc = cyc;
                res = result;
                break;
            end
            if (spam && cyc <= 4) begin
                start = 1'b1; in_a = rand_wide(); in_b = rand_wide();
                in_m = rand_wide(); subtract = ~s;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (lat_cyc < 0) chk("done_timeout", wv_t'(1'b0), wv_t'(1'b1));
        // A start presented during the done cycle must also be ignored.
        start = spam;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_drop_after_done", wv_t'(busy), wv_t'(1'b0));
        chk("result_hold", wv_t'(result), wv_t'(res));
    endtask

    int           lat, np, bad;
    logic [W-1:0] r, ob, ma, aa, ba, ones;
    logic         os, sa;

    initial begin
        ones = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_result", wv_t'(result), '0);
        chk("rst_ctrl", wv_t'({busy, done, add_start, add_subtract}), '0);
        chk("rst_ops", wv_t'(add_in_a | add_in_b), '0);

        adder_lat = 1;
        run_op(W'(9), W'(7), W'(13), 1'b0, 1'b0, lat, np, r, os, ob);
        chk("add_wrap_res", wv_t'(r), wv_t'(3));
        chk("add_wrap_lat", wv_t'(lat), wv_t'(5));
        chk("add_wrap_pulses", wv_t'(np), wv_t'(2));

        run_op(W'(3), W'(5), W'(13), 1'b1, 1'b0, lat, np, r, os, ob);
        chk("sub_borrow_res", wv_t'(r), wv_t'(11));
        chk("sub_borrow_lat", wv_t'(lat), wv_t'(5));
        chk("sub_borrow_op2_sub", wv_t'(os), wv_t'(1'b0));
        chk("sub_borrow_op2_b", wv_t'(ob), wv_t'(13));

        run_op(W'(5), W'(3), W'(13), 1'b1, 1'b0, lat, np, r, os, ob);
        chk("sub_fast_res", wv_t'(r), wv_t'(2));
`ifdef CONST_TIME_EN
        chk("sub_fast_lat", wv_t'(lat), wv_t'(5));
        chk("sub_fast_pulses", wv_t'(np), wv_t'(2));
`else
        chk("sub_fast_lat", wv_t'(lat), wv_t'(3));
        chk("sub_fast_pulses", wv_t'(np), wv_t'(1));
`endif

        run_op(ones - W'(1), ones - W'(1), ones, 1'b0, 1'b0, lat, np, r, os, ob);
        chk("add_carry_res", wv_t'(r), wv_t'(ones - W'(2)));
        chk("add_carry_pulses", wv_t'(np), wv_t'(2));

        run_op(W'(12), W'(0), W'(13), 1'b0, 1'b0, lat, np, r, os, ob);
        chk("add_noreduce_res", wv_t'(r), wv_t'(12));

        run_op(W'(9), W'(7), W'(13), 1'b0, 1'b1, lat, np, r, os, ob);
        chk("spam_res", wv_t'(r), wv_t'(3));
        chk("spam_lat", wv_t'(lat), wv_t'(5));
        chk("spam_pulses", wv_t'(np), wv_t'(2));

        // Reset in the second GO cycle; the adder's late done must be ignored.
        start = 1'b1; in_a = W'(9); in_b = W'(7); in_m = W'(13); subtract = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_test_op2_go", wv_t'(add_start), wv_t'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_result", wv_t'(result), '0);
        chk("midrst_ctrl", wv_t'({busy, done, add_start, add_subtract}), '0);
        chk("midrst_ops", wv_t'(add_in_a | add_in_b), '0);
        bad = 0;
        repeat (6) begin
            if (done || busy) bad++;
            @(posedge clk); #1;
        end
        chk("midrst_quiet", wv_t'(bad), '0);
        run_op(W'(10), W'(8), W'(13), 1'b0, 1'b0, lat, np, r, os, ob);
        chk("after_rst_res", wv_t'(r), wv_t'(5));

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                ma = W'($urandom_range(2, 5000));
                aa = W'($urandom() % ma[31:0]);
                ba = W'($urandom() % ma[31:0]);
            end else begin
                ma = rand_wide() | (W'(1) << (W - 1));
                aa = rand_wide() >> 1;
                ba = rand_wide() >> ($urandom_range(1, 3));
            end
            sa = 1'(($urandom() >> 3) & 1);
            adder_lat = $urandom_range(1, 3);
            run_op(aa, ba, ma, sa, 1'b0, lat, np, r, os, ob);
            chk("rand_res", wv_t'(r), wv_t'(ref_mod(aa, ba, ma, sa)));
            chk("rand_pulses", wv_t'(np), wv_t'(exp_ops(aa, ba, sa)));
            if (adder_lat == 1)
                chk("rand_lat", wv_t'(lat), wv_t'(2 * exp_ops(aa, ba, sa) + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
